// File: rtl/mult_unit_pkg.sv
// Shared definitions for the HI/LO multiplier: FSM state encodings and the default operand width.
package mult_unit_pkg;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_CNT_W = 6;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_FIX  = 2'd2,
        MULT_DONE = 2'd3
    } mult_state_e;

endpackage

// File: rtl/mult_unit.sv
// Iterative radix-2 shift-add multiplier. Signed operands are reduced to magnitudes,
// multiplied unsigned over WIDTH cycles, then the sign is restored in a single FIX cycle.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = MULT_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mult_state_e        state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // The upper half never exceeds WIDTH bits before the add, so WIDTH+1 bits hold the carry.
        sum     = acc_q[2*WIDTH:WIDTH] + {1'b0, mcand_q};
        product = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];

        unique case (state_q)
            MULT_IDLE, MULT_DONE: begin
                if (start_mult) begin
                    state_d  = MULT_RUN;
                    mcand_d  = (mult_sign && srca[WIDTH-1]) ? -srca : srca;
                    mplier_d = (mult_sign && srcb[WIDTH-1]) ? -srcb : srcb;
                    neg_d    = mult_sign & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d  = MULT_IDLE;
                end
            end
            MULT_RUN: begin
                if (mplier_q[0]) begin
                    acc_d = {1'b0, sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = acc_q >> 1;
                end
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = MULT_FIX;
                end
            end
            MULT_FIX: begin
                hi_d    = product[2*WIDTH-1:WIDTH];
                lo_d    = product[WIDTH-1:0];
                state_d = MULT_DONE;
            end
            default: state_d = MULT_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= MULT_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign busy = (state_q == MULT_RUN) || (state_q == MULT_FIX);
    assign done = (state_q == MULT_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Scoreboard bench for mult_unit: each launch pushes the model product and its due cycle,
// and a monitor pops and compares on every done pulse while checking hi/lo never change otherwise.
module tb_mult_unit;

    localparam int W       = 32;
    localparam int LATENCY = W + 2;  // negedge before E0 to the negedge after E(W+1)

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           due;
    } exp_t;

    logic         clk;
    logic         reset;
    logic         start_mult;
    logic         mult_sign;
    logic [W-1:0] srca;
    logic [W-1:0] srcb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    exp_t         sb[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    logic [W-1:0] exp_hi      = '0;
    logic [W-1:0] exp_lo      = '0;

    mult_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .start_mult(start_mult),
        .mult_sign (mult_sign),
        .srca      (srca),
        .srcb      (srcb),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [2*W-1:0] model(input logic sign, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [2*W-1:0] ea;
        logic [2*W-1:0] eb;
        ea = sign ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        eb = sign ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return ea * eb;
    endfunction

    // Scoreboard monitor: done must match the oldest pending entry at exactly its due cycle.
    always @(negedge clk) begin
        if (reset) begin
            if (done) begin
                vectors++;
                if (sb.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_done: cyc=%0d hi=%h lo=%h, no operation pending", cyc, hi, lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (hi !== e.hi || lo !== e.lo || cyc != e.due) begin
                        miscompares++;
                        $display("FAIL product: got hi=%h lo=%h at cyc %0d, expected hi=%h lo=%h at cyc %0d",
                                 hi, lo, cyc, e.hi, e.lo, e.due);
                    end
                    exp_hi = e.hi;
                    exp_lo = e.lo;
                end
            end else if (sb.size() != 0 && cyc >= sb[0].due) begin
                exp_t e;
                e = sb.pop_front();
                vectors++;
                miscompares++;
                $display("FAIL missing_done: no done by cyc %0d, expected hi=%h lo=%h", cyc, e.hi, e.lo);
            end
            vectors++;
            if (hi !== exp_hi || lo !== exp_lo) begin
                miscompares++;
                $display("FAIL hold: cyc=%0d hi=%h lo=%h, expected held hi=%h lo=%h",
                         cyc, hi, lo, exp_hi, exp_lo);
            end
        end
    end

    task automatic drive_start(input logic sign, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        exp_t e;
        p          = model(sign, a, b);
        e.hi       = p[2*W-1:W];
        e.lo       = p[W-1:0];
        e.due      = cyc + LATENCY;
        sb.push_back(e);
        start_mult = 1'b1;
        mult_sign  = sign;
        srca       = a;
        srcb       = b;
    endtask

    task automatic launch(input logic sign, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        drive_start(sign, a, b);
    endtask

    // Waits for done, checking busy each cycle; optionally pulses an ignored start at pulse_at.
    task automatic wait_done(input int pulse_at);
        bit seen;
        seen = 1'b0;
        for (int i = 1; i <= LATENCY + 6; i++) begin
            @(negedge clk);
            start_mult = 1'b0;
            if (done) begin
                seen = 1'b1;
                break;
            end
            vectors++;
            if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy_run: cycle %0d busy=%b, expected 1", i, busy);
            end
            if (i == pulse_at) begin
                start_mult = 1'b1;
                mult_sign  = 1'b0;
                srca       = 32'd2;
                srcb       = 32'd2;
            end
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL done_timeout: done=%b, expected 1 within %0d cycles", done, LATENCY + 6);
        end else if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_done: busy=%b in done cycle, expected 0", busy);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vectors++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                miscompares++;
                $display("FAIL idle: busy=%b done=%b, expected 0 0", busy, done);
            end
        end
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        start_mult = 1'b1;
        mult_sign  = 1'b0;
        srca       = 32'd9;
        srcb       = 32'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            miscompares++;
            $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", busy, done, hi, lo);
        end
        start_mult = 1'b0;
        reset      = 1'b1;
        idle_check(2);
    endtask

    task automatic test_unsigned();
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0);
        launch(1'b0, 32'h0000_0000, 32'hDEAD_BEEF);
        wait_done(0);
        idle_check(1);
    endtask

    task automatic test_signed();
        launch(1'b1, 32'hFFFF_FFFD, 32'h0000_0005);
        wait_done(0);
        launch(1'b1, 32'h8000_0000, 32'h8000_0000);
        wait_done(0);
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(0);
        launch(1'b1, 32'h8000_0000, 32'h0000_0000);
        wait_done(0);
        idle_check(1);
    endtask

    task automatic test_ignored_start();
        launch(1'b0, 32'd7, 32'd6);
        wait_done(10);
        idle_check(3);
    endtask

    task automatic test_reset_mid_op();
        launch(1'b0, 32'h0000_1234, 32'h0000_0010);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            start_mult = 1'b0;
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== '0 || lo !== '0) begin
            miscompares++;
            $display("FAIL reset_abort: busy=%b done=%b hi=%h lo=%h, expected 0 0 0 0", busy, done, hi, lo);
        end
        reset = 1'b1;
        idle_check(LATENCY);
        launch(1'b0, 32'd3, 32'd4);
        wait_done(0);
    endtask

    task automatic test_back_to_back();
        launch(1'b0, 32'd2, 32'd3);
        wait_done(0);
        drive_start(1'b0, 32'd5, 32'd5);
        wait_done(0);
        idle_check(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            launch(1'($urandom_range(0, 1)), $urandom, $urandom);
            wait_done(0);
        end
        idle_check(1);
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected bench to finish");
        $fatal(1, "watchdog");
    end

endmodule
